// File: rtl/ir_pkg.sv
// Shared definitions for the IR line-sensor conditioner: tracking state
// encoding, per-channel position weight and the width of the signed
// position sum.
package ir_pkg;

   typedef enum logic [1:0] {
      NOLINE = 2'd0,
      TRACK  = 2'd1,
      LOST_L = 2'd2,
      LOST_R = 2'd3
   } trk_state_e;

   // Position weight of channel i in an n-channel array, symmetric about 0.
   function automatic int w(input int i, input int n);
      return 2 * i - (n - 1);
   endfunction

   // Signed width needed for the weighted sum of an n-channel array.
   function automatic int pos_w(input int n);
      return $clog2(n * n + 1) + 1;
   endfunction

endpackage

// File: rtl/ir_debounce.sv
// One IR channel: two-flop synchroniser, polarity normalisation and a
// mismatch-run debounce counter feeding a stable detection bit.
module ir_debounce
   import ir_pkg::*;
#(
   parameter int   DB_W       = 16,
   parameter logic ACTIVE_LVL = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ir_i,
   input  logic [DB_W-1:0] db_cycles_i,
   output logic            ir_o
);

   logic            sync1_q, sync2_q;
   logic            norm;
   logic            stable_q, stable_d;
   logic [DB_W-1:0] cnt_q, cnt_d;

   assign norm = sync2_q ^ ~ACTIVE_LVL;
   assign ir_o = stable_q;

   // Count consecutive mismatching cycles; accept the new level once the
   // run reaches db_cycles_i. A count already past a lowered threshold
   // simply saturates until the mismatch ends, so it never fires early.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (norm != stable_q) begin
         if (cnt_q == db_cycles_i) begin
            stable_d = norm;
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   // Synchroniser and debounce state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync1_q  <= ir_i;
         sync2_q  <= sync1_q;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

endmodule

// File: rtl/ir_line_array.sv
// IR line-sensor array conditioner: per-channel debounce, registered
// active count / weighted position sum, line tracking FSM that remembers
// the side the line was lost on, and an optional sticky change IRQ
// (enabled by defining IR_LINE_IRQ_EN).
module ir_line_array
   import ir_pkg::*;
#(
   parameter  int   N_CH       = 5,
   parameter  int   DB_W       = 16,
   parameter  logic ACTIVE_LVL = 1'b1,
   localparam int   POS_W      = pos_w(N_CH),
   localparam int   CW         = $clog2(N_CH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_CH-1:0]         ir_i,
   input  logic [DB_W-1:0]         db_cycles_i,
   input  logic                    irq_ack_i,
   output logic [N_CH-1:0]         ir_o,
   output logic [CW-1:0]           act_cnt_o,
   output logic signed [POS_W-1:0] pos_sum_o,
   output logic [1:0]              state_o,
   output logic                    irq_o
);

   logic [N_CH-1:0]         ir_db;
   logic [CW-1:0]           act_q, act_d;
   logic signed [POS_W-1:0] pos_q, pos_d;
   trk_state_e              state_q, state_d;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      ir_debounce #(
         .DB_W       (DB_W),
         .ACTIVE_LVL (ACTIVE_LVL)
      ) u_db (
         .clk         (clk),
         .rst_n       (rst_n),
         .ir_i        (ir_i[g]),
         .db_cycles_i (db_cycles_i),
         .ir_o        (ir_db[g])
      );
   end

   assign ir_o      = ir_db;
   assign act_cnt_o = act_q;
   assign pos_sum_o = pos_q;
   assign state_o   = state_q;

   // Popcount and weighted sum of the debounced detections.
   always_comb begin
      act_d = '0;
      pos_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (ir_db[i]) begin
            act_d = act_d + 1'b1;
            pos_d = pos_d + POS_W'(w(i, N_CH));
         end
      end
   end

   // Next tracking state; on loss the side comes from the last sum seen
   // while tracking, which is still held in pos_q.
   always_comb begin
      state_d = state_q;
      if (act_d != '0) begin
         state_d = TRACK;
      end else if (state_q == TRACK) begin
         if (pos_q[POS_W-1])    state_d = LOST_L;
         else if (pos_q != '0)  state_d = LOST_R;
         else                   state_d = NOLINE;
      end
   end

   // Position registers and FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q   <= '0;
         pos_q   <= '0;
         state_q <= NOLINE;
      end else begin
         act_q   <= act_d;
         pos_q   <= pos_d;
         state_q <= state_d;
      end
   end

`ifdef IR_LINE_IRQ_EN
   logic [N_CH-1:0] ir_prev_q;
   logic            irq_q, irq_d, irq_set;

   // Set on a detection change or on entry into a LOST state; set beats ack.
   always_comb begin
      irq_set = (ir_db != ir_prev_q) ||
                ((state_d != state_q) && (state_d == LOST_L || state_d == LOST_R));
      irq_d   = irq_set | (irq_q & ~irq_ack_i);
   end

   // Sticky IRQ flop and previous-detection snapshot for change detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_prev_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         ir_prev_q <= ir_db;
         irq_q     <= irq_d;
      end
   end

   assign irq_o = irq_q;
`else
   logic unused_ack;
   assign unused_ack = irq_ack_i;
   assign irq_o      = 1'b0;
`endif

endmodule
